instruction_fetcher: RTL
========================

INSTRUCTION_FETCHER -- requirements
Module: instruction_fetcher

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset.
REQ-002 clk  in  1  clock; all state SHALL change on its rising edge only.
REQ-003 reset  in  1  synchronous active-high reset.
REQ-004 fetcher_reset  in  1  high = hold fetcher idle; low = fetch the word at pc.
REQ-005 pc  in  32  byte address of the instruction; pc[1:0] SHALL be ignored.
REQ-006 fetcher_completed  out  1  fetched instruction valid.
REQ-007 instruction  out  32  fetched instruction word, driven from a register.
REQ-008 inval  in  1  clears the last-fetch buffer (store to instruction memory).
REQ-009 mem_req  out  1  byte read request.
REQ-010 mem_addr  out  32  byte address = {pc[31:2], byte_idx[1:0]}.
REQ-011 mem_ack  in  1  read accepted; mem_rdata valid in the same cycle.
REQ-012 mem_rdata  in  8  read byte.

Function
REQ-013 States SHALL be IDLE, REQ and DONE; byte_idx SHALL be a 2-bit counter.
REQ-014 Any state with fetcher_reset=1 SHALL go to IDLE next cycle; this overrides every other transition.
REQ-015 IDLE with fetcher_reset=0 and a buffer hit (buf_valid=1, buf_tag==pc[31:2]) SHALL go to DONE with no memory access.
REQ-016 IDLE with fetcher_reset=0 and a miss SHALL go to REQ with byte_idx=0.
REQ-017 mem_req SHALL be 1 exactly when state==REQ; mem_addr SHALL hold stable until mem_ack.
REQ-018 In REQ, mem_ack=1 SHALL shift mem_rdata into the assembly register; byte 0 SHALL land in bits 31:24 (big-endian).
REQ-019 In REQ, mem_ack with byte_idx<3 SHALL increment byte_idx; mem_ack with byte_idx==3 SHALL load instruction, set buf_tag=pc[31:2], set buf_valid=1 and go to DONE.
REQ-020 fetcher_completed SHALL be 1 exactly when state==DONE; DONE SHALL persist until fetcher_reset=1.
REQ-021 instruction SHALL keep its value while fetcher_reset=1 and after leaving DONE, until the next fill completes; the downstream decoder reads it after handshake.
REQ-022 A hit SHALL leave instruction unchanged, because it already holds the buffered word.
REQ-023 fetcher_reset=1 in REQ SHALL abort the fetch. A mem_ack in that cycle SHALL be ignored, and instruction, buf_tag and buf_valid SHALL be unchanged.
REQ-024 inval=1 SHALL clear buf_valid next cycle. If it coincides with a final-byte fill, the instruction SHALL update and buf_valid SHALL end 0.
REQ-025 Latency, counted from the first edge with fetcher_reset=0: hit SHALL complete after 1 cycle; miss with zero-wait memory SHALL complete after 5 cycles (1 IDLE + 4 REQ); each wait cycle SHALL add 1.
REQ-026 pc SHALL be treated as stable while fetcher_reset=0. pc[31:2] SHALL be sampled at the IDLE decision and at buf_tag capture.

Reset
REQ-027 reset=1 SHALL set state=IDLE, byte_idx=0, buf_valid=0, buf_tag=0, instruction=0 and the assembly register to 0.
REQ-028 During and after reset, fetcher_completed=0 and mem_req=0 SHALL hold until a new fetch starts.
REQ-029 reset SHALL override fetcher_reset, mem_ack and inval in the same cycle.
REQ-030 reset mid-REQ SHALL drop mem_req on the next cycle, and the byte accepted in that cycle SHALL be discarded.

Verification
REQ-031 Miss, zero-wait: pc=0x100, bytes 0xDE,0xAD,0xBE,0xEF -> mem_addr 0x100..0x103; instruction=0xDEADBEEF; completed 5 cycles after fetcher_reset falls.
REQ-032 Hit: repeat fetch at pc=0x102 -> no mem_req; completed after 1 cycle; instruction=0xDEADBEEF.
REQ-033 Wait states: 2 idle cycles before each ack -> mem_addr stable throughout; completed after 13 cycles.
REQ-034 Abort: fetcher_reset=1 in the cycle of the third ack -> IDLE next cycle; mem_req=0; instruction and buffer unchanged; then a fetch at pc=0x100 hits.
REQ-035 inval during DONE, then a re-fetch of the same pc -> full 4-byte miss sequence; new data 0x01020304 appears on instruction.
REQ-036 Reset mid-REQ -> instruction=0, completed=0 and buf_valid=0; the next fetch at 0x100 misses.

Source files
------------

// File: rtl/fetch_mem_if.sv
// fetch_mem_if: byte-wide read port between the instruction fetcher and instruction memory.
interface fetch_mem_if;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [7:0]  mem_rdata;

    modport master (output mem_req, output mem_addr, input mem_ack, input mem_rdata);
    modport slave  (input mem_req, input mem_addr, output mem_ack, output mem_rdata);
endinterface

// File: rtl/instruction_fetcher.sv
// instruction_fetcher: assembles a big-endian 32-bit word from four byte reads,
// with a one-entry last-fetch buffer that short-circuits repeat fetches.
module instruction_fetcher (
    input  logic        clk,
    input  logic        reset,
    input  logic        fetcher_reset,
    input  logic [31:0] pc,
    input  logic        inval,
    output logic        fetcher_completed,
    output logic [31:0] instruction,
    fetch_mem_if.master mem
);
    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    state_t      state_q, state_d;
    logic [1:0]  idx_q, idx_d;
    logic [31:0] asm_q, asm_d, instr_q, instr_d;
    logic [29:0] tag_q, tag_d;
    logic        valid_q, valid_d;
    logic        hit, fill, last;

    assign hit  = valid_q && tag_q == pc[31:2];
    // an ack in the same cycle as fetcher_reset is dropped so an aborted fetch leaves no trace
    assign fill = state_q == REQ && !fetcher_reset && mem.mem_ack;
    assign last = fill && idx_q == 2'd3;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= 2'd0;
            asm_q   <= 32'd0;
            instr_q <= 32'd0;
            tag_q   <= 30'd0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            asm_q   <= asm_d;
            instr_q <= instr_d;
            tag_q   <= tag_d;
            valid_q <= valid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (fetcher_reset)
            state_d = IDLE;
        else if (state_q == IDLE)
            state_d = hit ? DONE : REQ;
        else if (last)
            state_d = DONE;
    end

    always_comb begin
        idx_d   = state_q != REQ ? 2'd0 : idx_q + 2'(fill);
        asm_d   = fill ? {asm_q[23:0], mem.mem_rdata} : asm_q;
        instr_d = last ? asm_d : instr_q;
        tag_d   = last ? pc[31:2] : tag_q;
        // invalidation wins over a coincident fill
        valid_d = !inval && (last || valid_q);
    end

    always_comb begin
        mem.mem_req       = state_q == REQ;
        mem.mem_addr      = {pc[31:2], idx_q};
        fetcher_completed = state_q == DONE;
        instruction       = instr_q;
    end
endmodule
